ddr_rx_align: RTL and testbench

DDR_RX_ALIGN -- requirements
Module: ddr_rx_align

---
 rtl/ddr_rx_pkg.sv | 13 +
 rtl/ddr_rx_slicer.sv | 15 +
 rtl/ddr_rx_align.sv | 124 ++++++++++++
 tb/tb_ddr_rx_align.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rx_pkg.sv
// Shared definitions for the DDR receive word aligner: FSM state encoding and
// the default training pattern.
package ddr_rx_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] TRAIN_DEFAULT = 8'h5C;

endpackage

// File: rtl/ddr_rx_slicer.sv
// Combinational 8-of-16 window extraction: w = sr[offset+7 : offset].
module ddr_rx_slicer (
    input  logic [15:0] sr,
    input  logic [2:0]  offset,
    output logic [7:0]  w
);

    logic [15:0] shifted;

    always_comb begin
        shifted = sr >> offset;
        w       = shifted[7:0];
    end

endmodule

// File: rtl/ddr_rx_align.sv
// Bit-slip word aligner for a 2-bit DDR capture: hunts for the training word,
// confirms it MATCH_N times, then presents one aligned byte every 4 cycles.
module ddr_rx_align
    import ddr_rx_pkg::*;
#(
    parameter logic [7:0]  TRAIN   = TRAIN_DEFAULT,
    parameter int unsigned MATCH_N = 4
) (
    input  logic       c,
    input  logic       rst,
    input  logic [1:0] d,
    input  logic       train_en,
    output logic [7:0] q,
    output logic       q_valid,
    output logic       locked,
    output logic [2:0] offset
);

    localparam logic [3:0] MATCH_LAST = 4'(MATCH_N);

    state_t      state;
    state_t      state_next;
    logic [15:0] sr;
    logic [1:0]  phase;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [2:0]  offset_next;
    logic        skip;
    logic        skip_next;
    logic [7:0]  q_next;
    logic        q_valid_next;
    logic [7:0]  w;
    logic        boundary;
    logic        is_train;

    ddr_rx_slicer u_slicer (
        .sr     (sr),
        .offset (offset),
        .w      (w)
    );

    assign boundary = (phase == 2'd3);
    assign is_train = (w == TRAIN);
    assign locked   = (state == LOCKED);

    // skip marks a boundary to ignore: the first one after reset (history only
    // half filled) and the one right after every slip (window still settling).
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        offset_next  = offset;
        skip_next    = skip;
        q_next       = q;
        q_valid_next = 1'b0;
        if (boundary) begin
            unique case (state)
                SEARCH: begin
                    if (skip) begin
                        skip_next = 1'b0;
                    end else if (train_en) begin
                        if (is_train) begin
                            cnt_next   = 4'd1;
                            state_next = (MATCH_LAST == 4'd1) ? LOCKED : CHECK;
                        end else begin
                            offset_next = offset + 3'd1;
                            skip_next   = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (skip) begin
                        skip_next = 1'b0;
                    end else if (train_en && is_train) begin
                        cnt_next = cnt + 4'd1;
                        if (cnt + 4'd1 == MATCH_LAST) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        cnt_next   = '0;
                        state_next = SEARCH;
                    end
                end
                LOCKED: begin
                    if (train_en && !is_train) begin
                        cnt_next    = '0;
                        offset_next = offset + 3'd1;
                        skip_next   = 1'b1;
                        state_next  = SEARCH;
                    end else begin
                        q_next       = w;
                        q_valid_next = 1'b1;
                    end
                end
                default: begin
                    cnt_next   = '0;
                    state_next = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge c) begin
        if (rst) begin
            sr      <= '0;
            phase   <= '0;
            state   <= SEARCH;
            cnt     <= '0;
            offset  <= '0;
            skip    <= 1'b1;
            q       <= '0;
            q_valid <= 1'b0;
        end else begin
            sr      <= {d, sr[15:2]};
            phase   <= phase + 2'd1;
            state   <= state_next;
            cnt     <= cnt_next;
            offset  <= offset_next;
            skip    <= skip_next;
            q       <= q_next;
            q_valid <= q_valid_next;
        end
    end

endmodule

// File: tb/tb_ddr_rx_align.sv
// Randomized scoreboard bench for ddr_rx_align: a serial bit-stream model
// predicts lock/offset per cycle and every presented word.
module tb_ddr_rx_align;

    localparam logic [7:0] T  = 8'h5C;
    localparam int         MN = 4;

    logic       c = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] d = '0;
    logic [1:0] d2 = '0;
    logic       train_en = 1'b0;
    logic [7:0] q, q2;
    logic       q_valid, q_valid2, locked, locked2;
    logic [2:0] offset, offset2;

    always #5 c = ~c;

    ddr_rx_align #(.TRAIN(8'h5C), .MATCH_N(4)) dut (
        .c(c), .rst(rst), .d(d), .train_en(train_en),
        .q(q), .q_valid(q_valid), .locked(locked), .offset(offset)
    );

    ddr_rx_align #(.TRAIN(8'h5C), .MATCH_N(1)) dut1 (
        .c(c), .rst(rst), .d(d2), .train_en(1'b1),
        .q(q2), .q_valid(q_valid2), .locked(locked2), .offset(offset2)
    );

    int vec = 0;
    int errs = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [7:0] w;
        int         tag;
    } exp_t;
    exp_t       sbq[$];
    logic [7:0] seen[$];
    bit         txq[$];
    bit         tx2[$];

    // Reference model: stream pairs since reset plus the alignment rules.
    int         m_state, m_cnt, m_off, m_skip, m_n;
    logic [1:0] m_pairs [0:8191];

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int j = 0; j < 8; j++) txq.push_back(w[j]);
    endtask

    function automatic logic mbit(input int b);
        if (b < 2) return 1'b0;
        return m_pairs[b / 2][b % 2];
    endfunction

    task automatic model_edge(input logic r, input logic [1:0] p, input logic te);
        logic [7:0] wd;
        if (r) begin
            m_state = 0; m_cnt = 0; m_off = 0; m_skip = 1; m_n = 0;
            return;
        end
        m_n++;
        m_pairs[m_n] = p;
        if (m_n % 4 != 0) return;
        for (int j = 0; j < 8; j++) wd[j] = mbit(2 * (m_n - 8) + m_off + j);
        if (m_state == 2) begin
            if (te && wd != T) begin
                m_state = 0; m_cnt = 0; m_off = (m_off + 1) % 8; m_skip = 1;
            end else begin
                sbq.push_back('{wd, edge_cnt});
            end
        end else if (m_skip != 0) begin
            m_skip = 0;
        end else if (m_state == 0) begin
            if (te) begin
                if (wd == T) begin
                    m_cnt = 1;
                    m_state = (m_cnt == MN) ? 2 : 1;
                end else begin
                    m_off = (m_off + 1) % 8;
                    m_skip = 1;
                end
            end
        end else begin
            if (te && wd == T) begin
                m_cnt++;
                if (m_cnt == MN) m_state = 2;
            end else begin
                m_state = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic step(input logic r);
        logic [1:0] p, p2;
        logic [7:0] tw;
        tw = T;
        if (r) begin
            p  = 2'($urandom);
            p2 = 2'($urandom);
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (txq.size() == 0) push_word(tw);
                p[i] = txq.pop_front();
                if (tx2.size() == 0) for (int j = 0; j < 8; j++) tx2.push_back(tw[j]);
                p2[i] = tx2.pop_front();
            end
        end
        rst = r;
        d   = p;
        d2  = p2;
        @(posedge c);
        edge_cnt++;
        model_edge(r, p, train_en);
        #1;
        chk("locked", int'(locked), int'(m_state == 2));
        chk("offset", int'(offset), m_off);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    // Scoreboard monitor: every q_valid must match the oldest expected word
    // for this very edge; stale expectations are missed pulses.
    always @(negedge c) begin
        while (sbq.size() > 0 && sbq[0].tag < edge_cnt) begin
            vec++;
            errs++;
            $display("FAIL q_valid_missing: got 0 expected 1 for word %0h", sbq[0].w);
            void'(sbq.pop_front());
        end
        if (q_valid) begin
            seen.push_back(q);
            if (sbq.size() == 0 || sbq[0].tag != edge_cnt) begin
                vec++;
                errs++;
                $display("FAIL q_valid_unexpected: got 1 expected 0 (q=%0h, edge %0d)", q, edge_cnt);
            end else begin
                chk("q", int'(q), int'(sbq[0].w));
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st, idx, fell;
        logic [7:0] tw;
        tw = T;

        // Training aligned to offset 3; second instance aligned to offset 0.
        txq.delete();
        txq.push_back(1'b0);
        tx2.delete();
        for (int j = 2; j < 8; j++) tx2.push_back(tw[j]);
        train_en = 1'b1;
        step(1'b1);
        step(1'b1);
        chk("rst_q", int'(q), 0);
        chk("rst_q_valid", int'(q_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_offset", int'(offset), 0);
        run(7);
        chk("m1_locked_e7", int'(locked2), 0);
        run(1);
        chk("m1_locked_e8", int'(locked2), 1);
        chk("m1_offset", int'(offset2), 0);
        chk("slip_e8", int'(offset), 1);
        run(4);
        chk("m1_q_valid", int'(q_valid2), 1);
        chk("m1_q", int'(q2), 8'h5C);
        run(4);
        chk("slip_e16", int'(offset), 2);
        run(8);
        chk("slip_e24", int'(offset), 3);
        run(16);
        chk("lock_e40", int'(locked), 0);
        run(4);
        chk("lock_e44", int'(locked), 1);
        chk("lock_offset", int'(offset), 3);

        // Locked with training off: payload words must come out in order.
        train_en = 1'b0;
        st = seen.size();
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        run(48);
        idx = -1;
        for (int i = st; i < seen.size(); i++) begin
            if (seen[i] != 8'h5C) begin
                idx = i;
                break;
            end
        end
        if (idx < 0 || idx + 2 >= seen.size()) begin
            chk("payload_found", 0, 1);
        end else begin
            chk("payload0", int'(seen[idx]), 8'h01);
            chk("payload1", int'(seen[idx + 1]), 8'h02);
            chk("payload2", int'(seen[idx + 2]), 8'h03);
        end
        chk("payload_locked", int'(locked), 1);

        // Random payload while locked and training off.
        for (int i = 0; i < 24; i++) push_word(8'($urandom));
        run(136);
        train_en = 1'b1;
        run(8);
        chk("random_locked", int'(locked), 1);

        // One inserted bit: lock lost, offset advances by one, lock regained.
        txq.push_front(1'($urandom));
        fell = 0;
        repeat (80) begin
            step(1'b0);
            if (!locked) fell = 1;
        end
        chk("slip_unlock_seen", fell, 1);
        chk("slip_relock", int'(locked), 1);
        chk("slip_offset", int'(offset), 4);

        // Random misalignment and noisy data with random train_en.
        repeat ($urandom_range(0, 7)) txq.push_back(1'($urandom));
        for (int i = 0; i < 40; i++) push_word(8'($urandom));
        repeat (170) begin
            train_en = 1'($urandom);
            step(1'b0);
        end
        train_en = 1'b1;
        run(150);
        chk("search_relock", int'(locked), 1);

        // One-cycle reset while locked, then a CHECK interrupted by 8'hFF.
        txq.delete();
        for (int i = 0; i < 6; i++) push_word(tw);
        push_word(8'hFF);
        step(1'b1);
        chk("rst2_q", int'(q), 0);
        chk("rst2_q_valid", int'(q_valid), 0);
        chk("rst2_locked", int'(locked), 0);
        chk("rst2_offset", int'(offset), 0);
        run(28);
        chk("check_e28_locked", int'(locked), 0);
        chk("check_e28_offset", int'(offset), 2);
        run(4);
        chk("ff_e32_locked", int'(locked), 0);
        chk("ff_e32_offset", int'(offset), 2);
        run(12);
        chk("ff_e44_locked", int'(locked), 0);
        run(4);
        chk("ff_e48_locked", int'(locked), 1);
        chk("ff_e48_offset", int'(offset), 2);

        run(8);
        @(negedge c);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
